mul_share_arb: RTL and testbench

- Round-robin arbiter/sequencer that shares one truncating multiplier instance (mul_acc) among NREQ requesters.
- Each requester presents an operand pair with a valid/ready handshake.
- The block captures the winner's operands, drives the shared multiplier, registers the truncated product and returns it with the requester ID over a valid/ready response channel.
- Sits between the approximate-arithmetic datapath clients and the single multiplier resource.

---
 rtl/mul_arb_pkg.sv | 22 ++
 rtl/mul_acc.sv | 25 ++
 rtl/mul_share_arb.sv | 185 ++++++++++++++++++
 tb/tb_mul_share_arb.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_arb_pkg.sv
// rtl/mul_arb_pkg.sv - shared types and constants for the multiplier-sharing arbiter
//
// Contents:
//   state_e  - sequencer states (IDLE, CALC, RESP) with fixed 2-bit encoding
//   OPCNT_W  - width of the completed-operation counter
//   idw_f    - requester-ID width for a given requester count
package mul_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  localparam int OPCNT_W = 16;

  // A single requester still needs a one-bit ID field so port widths stay legal.
  function automatic int idw_f(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

endpackage

// File: rtl/mul_acc.sv
// rtl/mul_acc.sv - truncating unsigned multiplier shared by the arbiter
//
// Ports:
//   a  in  BWOP  operand A
//   b  in  BWOP  operand B
//   c  out BWOP  low BWOP bits of a*b
module mul_acc #(
  parameter int BWOP = 32,
  parameter int NAB  = 1
) (
  input  logic [BWOP-1:0] a,
  input  logic [BWOP-1:0] b,
  output logic [BWOP-1:0] c
);

  // This is the accurate variant: every approximate-bit count in range gives
  // the exact truncated product. An out-of-range NAB drives zero so that a
  // misconfigured instance is obvious rather than silently plausible.
  if (NAB >= 0 && NAB <= BWOP) begin : g_exact
    assign c = a * b;
  end else begin : g_bad_cfg
    assign c = '0;
  end

endmodule

// File: rtl/mul_share_arb.sv
// rtl/mul_share_arb.sv - round-robin sequencer sharing one mul_acc among NREQ requesters
//
// Ports:
//   clk        in   1          clock, all state on rising edge
//   rst        in   1          synchronous active-high reset
//   req_valid  in   NREQ       per-requester operand valid
//   req_ready  out  NREQ       per-requester accept strobe, one-hot or zero
//   req_a      in   NREQ*BWOP  packed operand A, requester i at [i*BWOP +: BWOP]
//   req_b      in   NREQ*BWOP  packed operand B, same packing
//   rsp_valid  out  1          result valid
//   rsp_ready  in   1          consumer accepts result
//   rsp_c      out  BWOP       truncated product
//   rsp_id     out  IDW        requester that owns rsp_c
//   op_count   out  16         completed-operation counter, wraps
module mul_share_arb
  import mul_arb_pkg::*;
#(
  parameter int  BWOP = 32,
  parameter int  NAB  = 1,
  parameter int  NREQ = 4,
  localparam int IDW  = idw_f(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*BWOP-1:0] req_a,
  input  logic [NREQ*BWOP-1:0] req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [BWOP-1:0]      rsp_c,
  output logic [IDW-1:0]       rsp_id,
  output logic [OPCNT_W-1:0]   op_count
);

  state_e               state_q, state_d;
  logic [IDW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [BWOP-1:0]      op_a_q, op_a_d;
  logic [BWOP-1:0]      op_b_q, op_b_d;
  logic [IDW-1:0]       cur_id_q, cur_id_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [BWOP-1:0]      rsp_c_q, rsp_c_d;
  logic [IDW-1:0]       rsp_id_q, rsp_id_d;
  logic [OPCNT_W-1:0]   op_count_q, op_count_d;

  logic                 win_found;
  logic [IDW-1:0]       win_idx;
  logic                 arb_en;
  logic                 grant;
  logic [IDW-1:0]       win_next;
  logic [BWOP-1:0]      win_a, win_b;
  logic [BWOP-1:0]      mul_c;

  // Returns {found, index} of the first asserted valid bit, scanning from ptr
  // upward and wrapping modulo NREQ (NREQ need not be a power of two).
  function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] valid,
                                           input logic [IDW-1:0]  ptr);
    logic           found;
    logic [IDW-1:0] idx;
    int unsigned    j;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = (32'(ptr) + 32'(k)) % 32'(NREQ);
      if (!found && valid[j]) begin
        found = 1'b1;
        idx   = j[IDW-1:0];
      end
    end
    return {found, idx};
  endfunction

  assign {win_found, win_idx} = rr_pick(req_valid, rr_ptr_q);

  // A new operand pair can only be taken when the pipeline slot is free: in
  // IDLE, or in RESP on the very cycle the held result is being consumed.
  always_comb begin
    arb_en = 1'b0;
    case (state_q)
      ST_IDLE: arb_en = 1'b1;
      ST_RESP: arb_en = rsp_ready;
      default: arb_en = 1'b0;
    endcase
  end

  // Gating with rst keeps req_ready low in the reset cycle, so no requester
  // believes it was accepted while the capture is being discarded.
  assign grant     = arb_en & win_found & ~rst;
  assign req_ready = grant ? (NREQ'(1) << win_idx) : '0;

  assign win_a    = req_a[int'(win_idx)*BWOP +: BWOP];
  assign win_b    = req_b[int'(win_idx)*BWOP +: BWOP];
  assign win_next = (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + 1'b1;

  mul_acc #(
    .BWOP (BWOP),
    .NAB  (NAB)
  ) u_mul (
    .a (op_a_q),
    .b (op_b_q),
    .c (mul_c)
  );

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    cur_id_d    = cur_id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_c_d     = rsp_c_q;
    rsp_id_d    = rsp_id_q;
    op_count_d  = op_count_q;

    case (state_q)
      ST_IDLE: begin
        if (grant) begin
          op_a_d   = win_a;
          op_b_d   = win_b;
          cur_id_d = win_idx;
          rr_ptr_d = win_next;
          state_d  = ST_CALC;
        end
      end

      ST_CALC: begin
        rsp_c_d     = mul_c;
        rsp_id_d    = cur_id_q;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end

      ST_RESP: begin
        if (rsp_ready) begin
          op_count_d  = op_count_q + 1'b1;
          rsp_valid_d = 1'b0;
          if (grant) begin
            op_a_d   = win_a;
            op_b_d   = win_b;
            cur_id_d = win_idx;
            rr_ptr_d = win_next;
            state_d  = ST_CALC;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        rsp_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      cur_id_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_c_q     <= '0;
      rsp_id_q    <= '0;
      op_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      cur_id_q    <= cur_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_c_q     <= rsp_c_d;
      rsp_id_q    <= rsp_id_d;
      op_count_q  <= op_count_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_c     = rsp_c_q;
  assign rsp_id    = rsp_id_q;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_mul_share_arb.sv
// tb/tb_mul_share_arb.sv - self-checking bench for mul_share_arb
module tb_mul_share_arb;

  localparam int BWOP = 32;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*BWOP-1:0] req_a;
  logic [NREQ*BWOP-1:0] req_b;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [BWOP-1:0]      rsp_c;
  logic [IDW-1:0]       rsp_id;
  logic [15:0]          op_count;

  always #5 clk = ~clk;

  mul_share_arb #(
    .BWOP (BWOP),
    .NAB  (1),
    .NREQ (NREQ)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_c     (rsp_c),
    .rsp_id    (rsp_id),
    .op_count  (op_count)
  );

  // Transaction-level reference: an accepted op spends one cycle "computing",
  // then sits in a one-deep response queue until the consumer takes it.
  typedef struct {
    logic [BWOP-1:0] c;
    logic [IDW-1:0]  id;
  } exp_t;

  exp_t        m_rsp[$];
  exp_t        m_pend;
  bit          m_calc;
  int          m_rr;
  logic [15:0] m_cnt;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic m_reset();
    m_rsp.delete();
    m_calc = 1'b0;
    m_rr   = 0;
    m_cnt  = '0;
  endtask

  task automatic set_op(input int i, input logic [BWOP-1:0] a, input logic [BWOP-1:0] b);
    req_a[i*BWOP +: BWOP] = a;
    req_b[i*BWOP +: BWOP] = b;
  endtask

  // Entered at posedge+1 with inputs already driven; checks, advances the
  // model across the next edge, and returns at the following posedge+1.
  task automatic cycle();
    int              win;
    logic [NREQ-1:0] exp_rdy;
    logic [BWOP-1:0] wa, wb;
    #1;
    win = -1;
    if (!rst && !m_calc && (m_rsp.size() == 0 || rsp_ready)) begin
      for (int k = 0; k < NREQ; k++) begin
        if (win < 0 && req_valid[(m_rr + k) % NREQ]) win = (m_rr + k) % NREQ;
      end
    end
    exp_rdy = (win >= 0) ? (4'(1) << win) : 4'b0000;
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    chk("rsp_valid", 64'(rsp_valid), 64'(m_rsp.size() != 0));
    if (m_rsp.size() != 0) begin
      chk("rsp_c", 64'(rsp_c), 64'(m_rsp[0].c));
      chk("rsp_id", 64'(rsp_id), 64'(m_rsp[0].id));
    end
    chk("op_count", 64'(op_count), 64'(m_cnt));
    if (rst) begin
      m_reset();
    end else begin
      if (m_rsp.size() != 0 && rsp_ready) begin
        void'(m_rsp.pop_front());
        m_cnt = m_cnt + 16'd1;
      end
      if (m_calc) begin
        m_rsp.push_back(m_pend);
        m_calc = 1'b0;
      end
      if (win >= 0) begin
        wa        = req_a[win*BWOP +: BWOP];
        wb        = req_b[win*BWOP +: BWOP];
        m_pend.c  = wa * wb;
        m_pend.id = IDW'(win);
        m_calc    = 1'b1;
        m_rr      = (win + 1) % NREQ;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    rst       = 1'b1;
    req_valid = '1;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    m_reset();
    @(posedge clk);
    #1;

    // Reset with all requesters asking: nothing may be accepted.
    cycle();
    cycle();
    chk("rst_c", 64'(rsp_c), 64'd0);
    chk("rst_id", 64'(rsp_id), 64'd0);
    chk("rst_cnt", 64'(op_count), 64'd0);
    rst       = 1'b0;
    req_valid = '0;

    // Single request 3*5 from requester 0.
    set_op(0, 32'd3, 32'd5);
    req_valid = 4'b0001;
    cycle();
    req_valid = '0;
    cycle();
    chk("t1_valid", 64'(rsp_valid), 64'd1);
    chk("t1_c", 64'(rsp_c), 64'd15);
    chk("t1_id", 64'(rsp_id), 64'd0);
    rsp_ready = 1'b1;
    cycle();
    rsp_ready = 1'b0;
    chk("t1_cnt", 64'(op_count), 64'd1);

    // All four requesting and held; grants rotate 0,1,2,3 every 2 cycles.
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) set_op(i, BWOP'(i + 1), 32'd10);
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    repeat (7) cycle();
    req_valid = '0;
    repeat (2) cycle();
    chk("t2_cnt", 64'(op_count), 64'd4);

    // Truncation of the product to BWOP bits.
    rsp_ready = 1'b0;
    set_op(0, 32'hFFFF_FFFF, 32'd2);
    req_valid = 4'b0001;
    cycle();
    req_valid = '0;
    cycle();
    chk("trunc_c", 64'(rsp_c), 64'hFFFF_FFFE);
    rsp_ready = 1'b1;
    cycle();

    // Backpressure: result held 5 cycles, requester 2 granted on release.
    rsp_ready = 1'b0;
    set_op(1, $urandom(), $urandom());
    set_op(2, 32'd7, 32'd9);
    req_valid = 4'b0010;
    cycle();
    req_valid = 4'b0110;
    cycle();
    repeat (5) cycle();
    rsp_ready = 1'b1;
    #1;
    chk("bp_grant2", 64'(req_ready), 64'b0100);
    cycle();
    req_valid = '0;
    cycle();
    chk("bp_c2", 64'(rsp_c), 64'd63);
    cycle();
    rsp_ready = 1'b0;

    // Reset during CALC: the operation is dropped and the pointer returns to 0.
    req_valid = 4'b0100;
    cycle();
    req_valid = '0;
    rst       = 1'b1;
    cycle();
    rst = 1'b0;
    chk("mr_valid", 64'(rsp_valid), 64'd0);
    chk("mr_cnt", 64'(op_count), 64'd0);
    repeat (3) cycle();
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    #1;
    chk("mr_rr", 64'(req_ready), 64'b0001);
    cycle();
    req_valid = '0;
    repeat (2) cycle();

    // Randomized traffic with occasional resets.
    repeat (400) begin
      rst       = ($urandom_range(0, 99) == 0);
      req_valid = NREQ'($urandom());
      for (int i = 0; i < NREQ; i++) set_op(i, $urandom(), $urandom());
      rsp_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    rst       = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (3) cycle();

    // Counter wrap: preload near the top, then complete two operations.
    force dut.op_count_q = 16'hFFFE;
    m_cnt = 16'hFFFE;
    cycle();
    release dut.op_count_q;
    repeat (2) begin
      set_op(0, $urandom(), $urandom());
      req_valid = 4'b0001;
      cycle();
      req_valid = '0;
      cycle();
      cycle();
    end
    chk("wrap_cnt", 64'(op_count), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
